// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the Hack program loader.
//   loader_state_t    : FSM state encoding for program_loader
//   SYNC_BYTE_DEFAULT : default frame start marker
//   CHK_W             : width of the running frame checksum
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CHK_W             = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SYNC   = 4'd1,
        ST_LEN_HI = 4'd2,
        ST_LEN_LO = 4'd3,
        ST_D_HI   = 4'd4,
        ST_D_LO   = 4'd5,
        ST_WRITE  = 4'd6,
        ST_CHK    = 4'd7,
        ST_DONE   = 4'd8,
        ST_ERROR  = 4'd9
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Parses a framed byte stream (SYNC, LEN_HI, LEN_LO, N big-endian words, CHK)
// and writes the words into the instruction ROM write port. The CPU is held in
// reset through cpu_hold while loading and after any framing/checksum error.
//
// Ports:
//   clk_in    in  : single clock, rising edge
//   reset     in  : synchronous active-high reset
//   start     in  : arms the loader (only honoured in IDLE/DONE/ERROR)
//   rx_data   in  : incoming byte
//   rx_valid  in  : rx_data valid
//   rx_ready  out : loader accepts a byte this cycle (registered state decode)
//   rom_addr  out : ROM write address
//   rom_data  out : ROM write data
//   rom_we    out : one-cycle ROM write strobe
//   cpu_hold  out : keep CPU in reset
//   busy      out : frame in progress
//   done      out : sticky success flag
//   error     out : sticky failure flag
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 15,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              rom_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Compare width wide enough for both the 16-bit length and the
    // ADDR_W+1-bit address counter, so 2^ADDR_W is representable.
    localparam int CMP_W = ((ADDR_W + 1) > 16) ? (ADDR_W + 1) : 16;

    loader_state_t     r_state;
    logic [ADDR_W:0]   r_addr;
    logic [15:0]       r_len;
    logic [7:0]        r_hi;
    logic [CHK_W-1:0]  r_chk;

    logic              r_rx_ready;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [15:0]       r_rom_data;
    logic              r_rom_we;
    logic              r_cpu_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic [CHK_W-1:0]  w_chk_sum;
    logic [15:0]       w_len_full;
    logic [CMP_W-1:0]  w_len_ext;
    logic [CMP_W-1:0]  w_max_len;
    logic              w_len_bad;
    logic              w_last_word;

    assign w_accept    = rx_valid & r_rx_ready;
    assign w_chk_sum   = r_chk + rx_data;
    assign w_len_full  = {r_len[15:8], rx_data};
    assign w_len_ext   = CMP_W'(w_len_full);
    assign w_max_len   = CMP_W'(1) << ADDR_W;
    assign w_len_bad   = (w_len_full == 16'd0) || (w_len_ext > w_max_len);
    // Index just written equals N-1  <=>  index+1 equals N.
    assign w_last_word = (CMP_W'(r_addr) + CMP_W'(1)) == CMP_W'(r_len);

    // Loader FSM with datapath registers; outputs are registered decodes of
    // the state being entered.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_len      <= 16'd0;
            r_hi       <= 8'd0;
            r_chk      <= '0;
            r_rx_ready <= 1'b0;
            r_rom_addr <= '0;
            r_rom_data <= 16'd0;
            r_rom_we   <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_rom_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state    <= ST_SYNC;
                        r_addr     <= '0;
                        r_chk      <= '0;
                        r_rx_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    // Anything other than the marker is silently dropped.
                    if (w_accept && (rx_data == SYNC_BYTE)) begin
                        r_state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        r_chk       <= w_chk_sum;
                        r_state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_chk      <= w_chk_sum;
                        if (w_len_bad) begin
                            r_state    <= ST_ERROR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= ST_D_HI;
                        end
                    end
                end
                ST_D_HI: begin
                    if (w_accept) begin
                        r_hi    <= rx_data;
                        r_chk   <= w_chk_sum;
                        r_state <= ST_D_LO;
                    end
                end
                ST_D_LO: begin
                    // Launch the write strobe as we enter WRITE; input stalls.
                    if (w_accept) begin
                        r_chk      <= w_chk_sum;
                        r_rom_we   <= 1'b1;
                        r_rom_addr <= r_addr[ADDR_W-1:0];
                        r_rom_data <= {r_hi, rx_data};
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_addr     <= r_addr + 1'b1;
                    r_rx_ready <= 1'b1;
                    r_state    <= w_last_word ? ST_CHK : ST_D_HI;
                end
                ST_CHK: begin
                    if (w_accept) begin
                        r_rx_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (rx_data == r_chk) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: fail safe with the CPU held.
                    r_state    <= ST_ERROR;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                    r_error    <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign rom_addr = r_rom_addr;
    assign rom_data = r_rom_data;
    assign rom_we   = r_rom_we;
    assign cpu_hold = r_cpu_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Table-driven bench for program_loader: each record is a complete byte stream
// plus the expected outcome and ROM writes; a few hand-written sequences cover
// start-while-busy and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 15;

    logic              clk_in   = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic [7:0]        rx_data  = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              rom_we;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    program_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_we   (rom_we),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [0:15][7:0] bytes;
        int               nbytes;
        bit               exp_done;
        int               nwr;
        logic [0:3][15:0] wdata;
    } vec_t;

    vec_t vecs [6];

    int checks   = 0;
    int failures = 0;

    // Write monitor: logs every strobe, its cycle, and rx_ready on that cycle.
    int          cyc = 0;
    int          wr_addr_q [$];
    int          wr_data_q [$];
    int          wr_cyc_q  [$];
    int          rdy_on_we = 0;

    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (rom_we) begin
            wr_addr_q.push_back(int'(rom_addr));
            wr_data_q.push_back(int'(rom_data));
            wr_cyc_q.push_back(cyc);
            if (rx_ready) rdy_on_we = rdy_on_we + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive bytes with rx_valid held high; a byte moves on when rx_ready is
    // seen high ahead of the edge that transfers it.
    task automatic send(input logic [0:15][7:0] b, input int n);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 200) begin
            @(negedge clk_in);
            rx_valid = 1'b1;
            rx_data  = b[i];
            if (rx_ready) i = i + 1;
            guard = guard + 1;
        end
        @(negedge clk_in);
        rx_valid = 1'b0;
        check("send_timeout", 32'(guard >= 200), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 20) begin
            @(negedge clk_in);
            g = g + 1;
        end
        check({tag, "_idle_timeout"}, 32'(g >= 20), 32'd0);
    endtask

    task automatic pulse_start(input string tag, input bit exp_arm);
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        if (exp_arm) begin
            check({tag, "_arm_hold"},  32'(cpu_hold), 32'd1);
            check({tag, "_arm_busy"},  32'(busy),     32'd1);
            check({tag, "_arm_ready"}, 32'(rx_ready), 32'd1);
            check({tag, "_arm_done"},  32'(done),     32'd0);
            check({tag, "_arm_err"},   32'(error),    32'd0);
        end
    endtask

    task automatic check_result(input string tag, input int base, input int rdy_base,
                                input bit exp_done, input int nwr,
                                input logic [0:3][15:0] wdata);
        check({tag, "_done"},  32'(done),     32'(exp_done));
        check({tag, "_error"}, 32'(error),    32'(!exp_done));
        check({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
        check({tag, "_busy"},  32'(busy),     32'd0);
        check({tag, "_nwr"},   32'(wr_addr_q.size() - base), 32'(nwr));
        check({tag, "_rdy_on_we"}, 32'(rdy_on_we - rdy_base), 32'd0);
        for (int w = 0; w < nwr && (base + w) < wr_addr_q.size(); w++) begin
            check($sformatf("%s_addr%0d", tag, w), 32'(wr_addr_q[base + w]), 32'(w));
            check($sformatf("%s_data%0d", tag, w), 32'(wr_data_q[base + w]), 32'(wdata[w]));
            if (w > 0)
                check($sformatf("%s_gap%0d", tag, w),
                      32'(wr_cyc_q[base + w] - wr_cyc_q[base + w - 1]), 32'd3);
        end
    endtask

    task automatic run_vector(input int k);
        string tag;
        int    base;
        int    rdy_base;
        tag      = $sformatf("v%0d", k);
        base     = wr_addr_q.size();
        rdy_base = rdy_on_we;
        pulse_start(tag, 1'b1);
        send(vecs[k].bytes, vecs[k].nbytes);
        wait_idle(tag);
        check_result(tag, base, rdy_base, vecs[k].exp_done, vecs[k].nwr, vecs[k].wdata);
    endtask

    initial begin
        logic [0:15][7:0] part;
        int               base;
        int               rdy_base;

        // Good frame: sum 00+02+12+34+AB+CD = 0x1C0 -> C0.
        vecs[0].bytes    = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, {8{8'h00}}};
        vecs[0].nbytes   = 8;
        vecs[0].exp_done = 1'b1;
        vecs[0].nwr      = 2;
        vecs[0].wdata    = {16'h1234, 16'hABCD, {2{16'h0000}}};
        // Leading garbage 00 FF.
        vecs[1].bytes    = {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, {6{8'h00}}};
        vecs[1].nbytes   = 10;
        vecs[1].exp_done = 1'b1;
        vecs[1].nwr      = 2;
        vecs[1].wdata    = {16'h1234, 16'hABCD, {2{16'h0000}}};
        // Bad checksum: words still written.
        vecs[2].bytes    = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1, {8{8'h00}}};
        vecs[2].nbytes   = 8;
        vecs[2].exp_done = 1'b0;
        vecs[2].nwr      = 2;
        vecs[2].wdata    = {16'h1234, 16'hABCD, {2{16'h0000}}};
        // Zero length.
        vecs[3].bytes    = {8'hA5, 8'h00, 8'h00, {13{8'h00}}};
        vecs[3].nbytes   = 3;
        vecs[3].exp_done = 1'b0;
        vecs[3].nwr      = 0;
        vecs[3].wdata    = '0;
        // Length 0x8001 > 2^15.
        vecs[4].bytes    = {8'hA5, 8'h80, 8'h01, {13{8'h00}}};
        vecs[4].nbytes   = 3;
        vecs[4].exp_done = 1'b0;
        vecs[4].nwr      = 0;
        vecs[4].wdata    = '0;
        // N=4 back-to-back: sum 04+01+..+08 = 0x28.
        vecs[5].bytes    = {8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08, 8'h28, {4{8'h00}}};
        vecs[5].nbytes   = 12;
        vecs[5].exp_done = 1'b1;
        vecs[5].nwr      = 4;
        vecs[5].wdata    = {16'h0102, 16'h0304, 16'h0506, 16'h0708};

        // Reset values while reset is applied.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we",    32'(rom_we),   32'd0);
        check("rst_addr",  32'(rom_addr), 32'd0);
        check("rst_data",  32'(rom_data), 32'd0);
        check("rst_hold",  32'(cpu_hold), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_error", 32'(error),    32'd0);
        reset = 1'b0;
        @(negedge clk_in);

        for (int k = 0; k < 6; k++) begin
            run_vector(k);
            if (k == 2) begin
                // Error keeps the CPU held until re-armed.
                repeat (4) @(negedge clk_in);
                check("v2_hold_sticky", 32'(cpu_hold), 32'd1);
                check("v2_err_sticky",  32'(error),    32'd1);
            end
        end

        // start while busy is ignored: frame still completes normally.
        base     = wr_addr_q.size();
        rdy_base = rdy_on_we;
        pulse_start("sb", 1'b1);
        part = {8'hA5, 8'h00, 8'h02, {13{8'h00}}};
        send(part, 3);
        pulse_start("sb_mid", 1'b0);
        check("sb_mid_busy", 32'(busy), 32'd1);
        part = {8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, {11{8'h00}}};
        send(part, 5);
        wait_idle("sb");
        check_result("sb", base, rdy_base, 1'b1, 2, vecs[0].wdata);

        // Reset after the first data byte: reset values, no write.
        base = wr_addr_q.size();
        pulse_start("mr", 1'b1);
        part = {8'hA5, 8'h00, 8'h02, 8'h12, {12{8'h00}}};
        send(part, 4);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        check("mr_ready", 32'(rx_ready), 32'd0);
        check("mr_hold",  32'(cpu_hold), 32'd0);
        check("mr_busy",  32'(busy),     32'd0);
        check("mr_done",  32'(done),     32'd0);
        check("mr_error", 32'(error),    32'd0);
        check("mr_addr",  32'(rom_addr), 32'd0);
        check("mr_data",  32'(rom_data), 32'd0);
        repeat (3) @(negedge clk_in);
        check("mr_no_we", 32'(wr_addr_q.size() - base), 32'd0);
        run_vector(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader that writes a Hack program into the instruction ROM (`ROM32k` write port) that the CPU reads. It parses a framed stream (sync, length, big-endian 16-bit words, checksum) from a UART RX or similar byte source. It holds the CPU in reset via `cpu_hold` while loading and releases it only after a frame passes its checksum. It sits beside `computer`: its write port feeds the ROM, and `cpu_hold` is ORed into the CPU reset.

## Interface
Parameters:
- `ADDR_W`, 15, ROM address width; maximum frame length is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5, frame start marker.

Ports:
- `clk_in` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that arms the loader; ignored unless in IDLE, DONE or ERROR.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader accepts a byte this cycle. A transfer occurs when `rx_valid && rx_ready`.
- `rom_addr` out ADDR_W: write address.
- `rom_data` out 16: write data.
- `rom_we` out 1: one-cycle write strobe.
- `cpu_hold` out 1: keeps the CPU in reset while loading or after an error.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: sticky success flag; cleared by `start` or `reset`.
- `error` out 1: sticky failure flag; cleared by `start` or `reset`.

## Operation
- **Frame format:** SYNC_BYTE, LEN_HI, LEN_LO, then N words sent high byte first, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = 8-bit modular sum of LEN_HI, LEN_LO and all data bytes. SYNC is excluded.
- **States:** IDLE, SYNC, LEN_HI, LEN_LO, D_HI, D_LO, WRITE, CHK, DONE, ERROR.
- **IDLE:** entered on reset; `rx_ready`=0. A `start` pulse moves to SYNC, asserts `cpu_hold`, zeroes the address counter and checksum, and clears `done` and `error`.
- **SYNC:** `rx_ready`=1. Bytes other than SYNC_BYTE are consumed and discarded. SYNC_BYTE moves to LEN_HI.
- **LEN_HI, LEN_LO:** each byte is captured and added to the checksum. After LEN_LO:
  - N=0 or N>2^ADDR_W goes to ERROR.
  - Otherwise go to D_HI.
- **D_HI:** capture the high byte, then go to D_LO.
- **D_LO:** capture the low byte, then go to WRITE. Both data bytes are added to the checksum.
- **WRITE:** lasts exactly one cycle.
  - `rom_we`=1, `rom_addr`=word index, `rom_data`={hi, lo}, `rx_ready`=0.
  - The index then increments.
  - If the index just written equals N-1, go to CHK; otherwise go to D_HI.
- **CHK:** one byte.
  - If it matches the running sum, go to DONE.
  - Otherwise go to ERROR. Words already written stay in the ROM.
- **DONE:** `done`=1, `cpu_hold`=0, `rx_ready`=0. A new `start` re-arms the loader.
- **ERROR:** `error`=1, `cpu_hold` stays 1 so a corrupt program never runs, `rx_ready`=0. Only `start` or `reset` leaves ERROR.
- **Arithmetic:** the checksum wraps mod 256. The length compare uses the full 16-bit N against 2^ADDR_W. The address counter is ADDR_W+1 bits internally so an N of 2^ADDR_W does not wrap before the compare.

## Timing
- **Reset values:** `rx_ready`=0, `rom_we`=0, `rom_addr`=0, `rom_data`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- **`cpu_hold` rises** the cycle after `start` is sampled. It falls the cycle after a good CHK byte is accepted, which is the same cycle `done` rises.
- **Write latency:** `rom_we` asserts in the cycle after the D_LO byte is accepted.
- **Throughput:** with `rx_valid` held high, each word costs 3 cycles (2 accepts plus 1 WRITE stall). No byte is dropped during the stall.
- **`rx_ready` is registered state decode** and must not depend combinationally on `rx_valid`.
- **`start` while busy:** ignored.
- **`reset` mid-frame:** on the next edge the loader returns to IDLE with reset values and no partial `rom_we`. Because `cpu_hold` falls, the ROM content is unspecified.

## Structure
- Package `loader_pkg`: the state enum `loader_state_t`, `SYNC_BYTE_DEFAULT`, and the checksum width constant.
- One module with a single FSM plus datapath registers (hi byte, length, address counter, checksum). No sub-module is needed.
- Integration: CPU reset = `reset | cpu_hold`. The ROM gains a write port driven by `rom_we`/`rom_addr`/`rom_data`.

## Test plan
- **Good frame:** `start`, then A5 00 02 12 34 AB CD C0 → writes (0, 0x1234) and (1, 0xABCD); `done`=1; `cpu_hold` falls; `error`=0.
- **Leading garbage:** 00 FF before the same frame → garbage discarded; identical writes; `done`=1.
- **Bad checksum:** the same frame with checksum C1 → both words written, `error`=1, `done`=0, `cpu_hold`=1 until the next `start`.
- **Bad length:** A5 00 00 → ERROR right after LEN_LO with no `rom_we`. A5 80 01 → ERROR with no `rom_we`.
- **Back-to-back stream:** `rx_valid` held high with back-to-back bytes for N=4 → `rom_we` pulses every 3 cycles, all four words correct, `rx_ready`=0 on each WRITE cycle.
- **Reset mid-frame:** `reset` after the first data byte → all outputs return to reset values next cycle. A following `start` plus the good frame completes normally.
